fq_ptr_arbiter: RTL

// Shares the single free-pointer queue (10-bit buffer pointers, 511 entries) among NUM_ALLOC allocating

---
 rtl/fq_ptr_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fq_ptr_arbiter.sv
// fq_ptr_arbiter
// Shares one free-pointer queue (10-bit buffer pointers, 511 entries) between NUM_ALLOC
// allocating requesters and NUM_REL releasing requesters. Each path uses its own round-robin
// arbiter. At most one pop (FQ_rd) and one push (FQ_wr) happen per cycle, and both may happen
// in the same cycle. The block also counts outstanding pointers and flags releases that arrive
// when no pointer is outstanding.
//
// Ports
//   clk            system clock
//   rstn           synchronous reset, active low
//   alloc_req      level allocation requests, held until the matching alloc_gnt bit is seen
//   alloc_gnt      one-hot, 1-cycle grant pulse (registered)
//   alloc_ptr      granted pointer, valid while alloc_gnt != 0
//   rel_req        level release requests, held until the matching rel_ack bit is seen
//   rel_ptr        release pointer of requester i on bits [10*i+9:10*i]
//   rel_ack        one-hot, 1-cycle accept pulse (registered)
//   FQ_act         free queue initialised and accepting traffic
//   ptr_fifo_empty free queue empty
//   ptr_dout_s     free queue head (first-word-fall-through)
//   FQ_rd          pop free queue (combinational)
//   FQ_wr          push to free queue (registered)
//   ptr_din        pushed pointer, [9:0] pointer, [15:10] zero
//   out_cnt        pointers allocated and not yet released
//   fq_ready       FQ_act & !ptr_fifo_empty
//   rel_err        sticky, set when a release is accepted while out_cnt == 0

module fq_ptr_arbiter #(
  parameter int unsigned NUM_ALLOC = 4,
  parameter int unsigned NUM_REL   = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_ALLOC-1:0]    alloc_req,
  output logic [NUM_ALLOC-1:0]    alloc_gnt,
  output logic [9:0]              alloc_ptr,
  input  logic [NUM_REL-1:0]      rel_req,
  input  logic [10*NUM_REL-1:0]   rel_ptr,
  output logic [NUM_REL-1:0]      rel_ack,
  input  logic                    FQ_act,
  input  logic                    ptr_fifo_empty,
  input  logic [9:0]              ptr_dout_s,
  output logic                    FQ_rd,
  output logic                    FQ_wr,
  output logic [15:0]             ptr_din,
  output logic [9:0]              out_cnt,
  output logic                    fq_ready,
  output logic                    rel_err
);

  localparam int unsigned AW = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1;
  localparam int unsigned RW = (NUM_REL > 1) ? $clog2(NUM_REL) : 1;
  localparam logic [9:0]  CntMax = 10'd511;

  typedef enum logic [0:0] {StWaitInit, StRun} state_e;

  state_e         state_q;
  logic [AW-1:0]  alloc_rr_q;
  logic [RW-1:0]  rel_rr_q;

  logic [NUM_ALLOC-1:0] req_m;
  logic [NUM_REL-1:0]   rel_m;
  logic                 run;
  logic                 rel_fire;
  logic [AW-1:0]        alloc_win;
  logic [RW-1:0]        rel_win;
  int unsigned          a_idx;
  int unsigned          r_idx;
  logic [9:0]           rel_sel;
  logic [AW-1:0]        alloc_rr_next;
  logic [RW-1:0]        rel_rr_next;
  logic [NUM_ALLOC-1:0] alloc_onehot;
  logic [NUM_REL-1:0]   rel_onehot;

  assign run      = (state_q == StRun);
  // The requester granted last cycle still shows its request; mask it so it is not granted twice.
  assign req_m    = alloc_req & ~alloc_gnt;
  assign rel_m    = rel_req & ~rel_ack;
  assign FQ_rd    = run & ~ptr_fifo_empty & (|req_m);
  assign rel_fire = run & (|rel_m);
  assign fq_ready = FQ_act & ~ptr_fifo_empty;

  // Round-robin pick: scan from the highest offset down so the lowest offset from the pointer
  // is the last assignment and therefore wins.
  always_comb begin
    alloc_win = '0;
    a_idx     = 0;
    for (int k = NUM_ALLOC - 1; k >= 0; k--) begin
      a_idx = (32'(alloc_rr_q) + 32'(k)) % NUM_ALLOC;
      if (req_m[a_idx[AW-1:0]]) alloc_win = a_idx[AW-1:0];
    end
  end

  always_comb begin
    rel_win = '0;
    r_idx   = 0;
    for (int k = NUM_REL - 1; k >= 0; k--) begin
      r_idx = (32'(rel_rr_q) + 32'(k)) % NUM_REL;
      if (rel_m[r_idx[RW-1:0]]) rel_win = r_idx[RW-1:0];
    end
  end

  always_comb begin
    rel_sel = '0;
    for (int i = 0; i < NUM_REL; i++) begin
      if (rel_win == RW'(i)) rel_sel = rel_ptr[10*i +: 10];
    end
  end

  always_comb begin
    alloc_onehot            = '0;
    alloc_onehot[alloc_win] = 1'b1;
    rel_onehot              = '0;
    rel_onehot[rel_win]     = 1'b1;
    alloc_rr_next = (alloc_win == AW'(NUM_ALLOC - 1)) ? '0 : alloc_win + AW'(1);
    rel_rr_next   = (rel_win == RW'(NUM_REL - 1)) ? '0 : rel_win + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StWaitInit;
      alloc_rr_q <= '0;
      rel_rr_q   <= '0;
      alloc_gnt  <= '0;
      alloc_ptr  <= '0;
      rel_ack    <= '0;
      FQ_wr      <= 1'b0;
      ptr_din    <= '0;
      out_cnt    <= '0;
      rel_err    <= 1'b0;
    end else begin
      unique case (state_q)
        StWaitInit: begin
          // Releases are held off here; requesters keep rel_req asserted until acked.
          alloc_gnt <= '0;
          rel_ack   <= '0;
          FQ_wr     <= 1'b0;
          if (FQ_act) state_q <= StRun;
        end
        StRun: begin
          if (FQ_rd) begin
            alloc_gnt  <= alloc_onehot;
            alloc_ptr  <= ptr_dout_s;
            alloc_rr_q <= alloc_rr_next;
          end else begin
            alloc_gnt <= '0;
          end

          if (rel_fire) begin
            rel_ack  <= rel_onehot;
            FQ_wr    <= 1'b1;
            ptr_din  <= {6'b0, rel_sel};
            rel_rr_q <= rel_rr_next;
          end else begin
            rel_ack <= '0;
            FQ_wr   <= 1'b0;
          end

          // A grant and an ack in the same cycle cancel out.
          if (FQ_rd && !rel_fire) begin
            if (out_cnt != CntMax) out_cnt <= out_cnt + 10'd1;
          end else if (rel_fire && !FQ_rd) begin
            if (out_cnt == 10'd0) rel_err <= 1'b1;
            else                  out_cnt <= out_cnt - 10'd1;
          end
        end
        default: state_q <= StWaitInit;
      endcase
    end
  end

endmodule
